// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM state
// encoding, supported opcodes and the select/aluop/immsrc encodings that
// the controller drives into the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } resultsrc_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alusrca_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alusrcb_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-unit <-> datapath bundle.
//   master: controller side (receives op/zero/mem_ready, drives enables,
//           selects, illegal and instret)
//   slave : datapath side
interface multicycle_controller_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic [6:0]           op;
  logic                 zero;
  logic                 mem_ready;
  logic                 pcwrite;
  logic                 adrsrc;
  logic                 memwrite;
  logic                 irwrite;
  logic                 regwrite;
  logic [1:0]           resultsrc;
  logic [1:0]           alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           aluop;
  logic [1:0]           immsrc;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, aluop, immsrc, illegal, instret
  );
endinterface

// File: rtl/imm_src_decoder.sv
// Combinational immediate-format decode from the opcode.
//   op_i     : IR opcode field
//   immsrc_o : 00 I, 01 S, 10 B, 11 J (unknown opcodes give 00)
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] immsrc_o
);

  always_comb begin
    immsrc_o = IMM_I;
    case (op_i)
      OP_SW:   immsrc_o = IMM_S;
      OP_BEQ:  immsrc_o = IMM_B;
      OP_JAL:  immsrc_o = IMM_J;
      default: immsrc_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle RV32I core.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   ctrl  : master side of the controller bundle (opcode, zero flag,
//           memory handshake in; enables, selects, illegal, instret out)
// All outputs except instret are combinational; instret is registered.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_controller_if.master    ctrl
);

  state_e               state_q, state_d;
  state_e               cur_state;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal, retire;
  resultsrc_e resultsrc;
  alusrca_e   alusrca;
  alusrcb_e   alusrcb;
  aluop_e     aluop;
  logic [1:0] immsrc;

  imm_src_decoder u_imm_src_decoder (
    .op_i     (ctrl.op),
    .immsrc_o (immsrc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // While reset is high the outputs are decoded as FETCH, then every
  // strobe is masked so no write can leak out of the reset cycle.
  always_comb begin
    state_d   = state_q;
    cur_state = reset ? S_FETCH : state_q;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    aluop     = ALUOP_ADD;

    case (cur_state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        irwrite   = ctrl.mem_ready;
        pcwrite   = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            // Unsupported opcodes retire as no-ops.
            illegal = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        state_d = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (ctrl.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (ctrl.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_RS2;
        aluop   = ALUOP_SUB;
        pcwrite = ctrl.zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
      retire   = 1'b0;
    end
  end

  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

  assign ctrl.pcwrite   = pcwrite;
  assign ctrl.adrsrc    = adrsrc;
  assign ctrl.memwrite  = memwrite;
  assign ctrl.irwrite   = irwrite;
  assign ctrl.regwrite  = regwrite;
  assign ctrl.resultsrc = resultsrc;
  assign ctrl.alusrca   = alusrca;
  assign ctrl.alusrcb   = alusrcb;
  assign ctrl.aluop     = aluop;
  assign ctrl.immsrc    = immsrc;
  assign ctrl.illegal   = illegal;
  assign ctrl.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller. Inputs change on the
// falling edge; combinational outputs and instret are sampled 1 time unit
// later, well away from the rising edge.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_IALU = 7'b0010011;
  localparam logic [6:0] T_BEQ  = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_BAD  = 7'b0000000;

  // {pcwrite, adrsrc, memwrite, irwrite, regwrite,
  //  resultsrc[1:0], alusrca[1:0], alusrcb[1:0], aluop[1:0], illegal}
  localparam logic [13:0] E_FETCH0 = 14'b0000_0_10_00_10_00_0;
  localparam logic [13:0] E_FETCH1 = 14'b1001_0_10_00_10_00_0;
  localparam logic [13:0] E_DECODE = 14'b0000_0_00_01_01_00_0;
  localparam logic [13:0] E_ILL    = 14'b0000_0_00_01_01_00_1;
  localparam logic [13:0] E_MEMADR = 14'b0000_0_00_10_01_00_0;
  localparam logic [13:0] E_MEMRD  = 14'b0100_0_00_00_00_00_0;
  localparam logic [13:0] E_MEMWB  = 14'b0000_1_01_00_00_00_0;
  localparam logic [13:0] E_MEMWR  = 14'b0110_0_00_00_00_00_0;
  localparam logic [13:0] E_EXR    = 14'b0000_0_00_10_00_10_0;
  localparam logic [13:0] E_EXI    = 14'b0000_0_00_10_01_10_0;
  localparam logic [13:0] E_ALUWB  = 14'b0000_1_00_00_00_00_0;
  localparam logic [13:0] E_BEQ0   = 14'b0000_0_00_10_00_01_0;
  localparam logic [13:0] E_BEQ1   = 14'b1000_0_00_10_00_01_0;
  localparam logic [13:0] E_JAL    = 14'b1000_0_00_01_10_00_0;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] ir_exp   = '0;
  logic [13:0] ctl;

  always #5 clk = ~clk;

  multicycle_controller_if #(.INSTRET_W(32)) bus ();

  multicycle_controller #(.INSTRET_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  assign ctl = {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite,
                bus.regwrite, bus.resultsrc, bus.alusrca, bus.alusrcb,
                bus.aluop, bus.illegal};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check controls and the retire count.
  task automatic cyc(input string tag, input logic rst, input logic [6:0] op_v,
                     input logic z, input logic rdy, input logic [13:0] exp);
    @(negedge clk);
    reset         = rst;
    bus.op        = op_v;
    bus.zero      = z;
    bus.mem_ready = rdy;
    #1;
    check({tag, ".ctl"}, {18'b0, ctl}, {18'b0, exp});
    check({tag, ".instret"}, bus.instret, ir_exp);
  endtask

  logic [6:0] imm_ops [8];
  logic [1:0] imm_exp [8];

  initial begin
    imm_ops = '{T_LW, T_SW, T_R, T_IALU, T_BEQ, T_JAL, T_BAD, 7'h7f};
    imm_exp = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};

    reset         = 1'b1;
    bus.op        = T_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.ctl", {18'b0, ctl}, {18'b0, E_FETCH0});
    check("reset.instret", bus.instret, 32'd0);

    // immsrc is pure opcode decode; sweep it while reset holds the FSM.
    for (int i = 0; i < 8; i++) begin
      bus.op = imm_ops[i];
      #1;
      check($sformatf("immsrc[%0d]", i), {30'b0, bus.immsrc}, {30'b0, imm_exp[i]});
    end

    // R-type
    cyc("r.fetch",  0, T_R, 0, 1, E_FETCH1);
    cyc("r.decode", 0, T_R, 0, 1, E_DECODE);
    cyc("r.exec",   0, T_R, 0, 1, E_EXR);
    cyc("r.wb",     0, T_R, 0, 1, E_ALUWB);
    ir_exp = 32'd1;

    // lw with two wait cycles in FETCH and in MEMREAD
    cyc("lw.fetch0", 0, T_LW, 0, 0, E_FETCH0);
    cyc("lw.fetch1", 0, T_LW, 0, 0, E_FETCH0);
    cyc("lw.fetch2", 0, T_LW, 0, 1, E_FETCH1);
    cyc("lw.decode", 0, T_LW, 0, 1, E_DECODE);
    cyc("lw.memadr", 0, T_LW, 0, 1, E_MEMADR);
    cyc("lw.rd0",    0, T_LW, 0, 0, E_MEMRD);
    cyc("lw.rd1",    0, T_LW, 0, 0, E_MEMRD);
    cyc("lw.rd2",    0, T_LW, 0, 1, E_MEMRD);
    cyc("lw.wb",     0, T_LW, 0, 1, E_MEMWB);
    ir_exp = 32'd2;

    // beq taken, then not taken
    cyc("beqt.fetch",  0, T_BEQ, 1, 1, E_FETCH1);
    cyc("beqt.decode", 0, T_BEQ, 1, 1, E_DECODE);
    cyc("beqt.beq",    0, T_BEQ, 1, 1, E_BEQ1);
    ir_exp = 32'd3;
    cyc("beqn.fetch",  0, T_BEQ, 0, 1, E_FETCH1);
    cyc("beqn.decode", 0, T_BEQ, 0, 1, E_DECODE);
    cyc("beqn.beq",    0, T_BEQ, 0, 1, E_BEQ0);
    ir_exp = 32'd4;

    // I-ALU
    cyc("i.fetch",  0, T_IALU, 0, 1, E_FETCH1);
    cyc("i.decode", 0, T_IALU, 0, 1, E_DECODE);
    cyc("i.exec",   0, T_IALU, 0, 1, E_EXI);
    cyc("i.wb",     0, T_IALU, 0, 1, E_ALUWB);
    ir_exp = 32'd5;

    // sw with three wait cycles in MEMWRITE
    cyc("sw.fetch",  0, T_SW, 0, 1, E_FETCH1);
    cyc("sw.decode", 0, T_SW, 0, 1, E_DECODE);
    cyc("sw.memadr", 0, T_SW, 0, 1, E_MEMADR);
    cyc("sw.wr0",    0, T_SW, 0, 0, E_MEMWR);
    cyc("sw.wr1",    0, T_SW, 0, 0, E_MEMWR);
    cyc("sw.wr2",    0, T_SW, 0, 0, E_MEMWR);
    cyc("sw.wr3",    0, T_SW, 0, 1, E_MEMWR);
    ir_exp = 32'd6;

    // illegal opcode
    cyc("ill.fetch",  0, T_BAD, 0, 1, E_FETCH1);
    cyc("ill.decode", 0, T_BAD, 0, 1, E_ILL);
    ir_exp = 32'd7;
    cyc("ill.after",  0, T_SW, 0, 0, E_FETCH0);

    // reset while stalled in MEMWRITE
    cyc("rsw.fetch",  0, T_SW, 0, 1, E_FETCH1);
    cyc("rsw.decode", 0, T_SW, 0, 1, E_DECODE);
    cyc("rsw.memadr", 0, T_SW, 0, 1, E_MEMADR);
    cyc("rsw.wr0",    0, T_SW, 0, 0, E_MEMWR);
    cyc("rsw.reset",  1, T_SW, 0, 0, E_FETCH0);
    ir_exp = 32'd0;

    // jal after reset
    cyc("jal.fetch",  0, T_JAL, 0, 1, E_FETCH1);
    cyc("jal.decode", 0, T_JAL, 0, 1, E_DECODE);
    cyc("jal.jal",    0, T_JAL, 0, 1, E_JAL);
    cyc("jal.wb",     0, T_JAL, 0, 1, E_ALUWB);
    ir_exp = 32'd1;
    cyc("jal.after",  0, T_R,   0, 0, E_FETCH0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. A Moore-style FSM sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the shared ALU's operand selects and `aluop` into the existing ALU decoder, and drives the enables for PC, IR, register file and memory. It supports a variable-latency memory through a `mem_ready` handshake and counts retired instructions.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `op`  in  7: opcode field of the IR.
- `zero`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory has completed the current access this cycle.
- `pcwrite`  out  1: PC register enable.
- `adrsrc`  out  1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite`  out  1: memory write strobe.
- `irwrite`  out  1: IR and OldPC enable.
- `regwrite`  out  1: register file write enable.
- `resultsrc`  out  2: result select (00 = ALUOut, 01 = Data, 10 = ALU result).
- `alusrca`  out  2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1).
- `alusrcb`  out  2: ALU B select (00 = rs2, 01 = ImmExt, 10 = constant 4).
- `aluop`  out  2: 00 = add, 01 = sub, 10 = decode funct3/funct7.
- `immsrc`  out  2: 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal`  out  1: one-cycle pulse in DECODE on an unsupported opcode.
- `instret`  out  `INSTRET_W`: retired-instruction count.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Signal defaults: enables and `illegal` are 0; selects are 00.
- `immsrc` is decoded combinationally from `op` in every state. Unknown opcodes give 00.

States, their outputs and their next states:
- **FETCH**: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite = pcwrite = `mem_ready`.
  - Stays in FETCH while `!mem_ready`; goes to DECODE when `mem_ready`.
- **DECODE**: alusrca=01, alusrcb=01, aluop=00 (computes the branch target into ALUOut). Next state by opcode:
  - lw, sw → MEMADR
  - R-type → EXECUTER
  - I-ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - any other opcode → FETCH, with `illegal`=1
- **MEMADR**: alusrca=10, alusrcb=01, aluop=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD**: adrsrc=1, resultsrc=00. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**: resultsrc=01, regwrite=1. Goes to FETCH.
- **MEMWRITE**: adrsrc=1, resultsrc=00, memwrite=1 held until `mem_ready`. Goes to FETCH on `mem_ready`.
- **EXECUTER**: alusrca=10, alusrcb=00, aluop=10. Goes to ALUWB.
- **EXECUTEI**: alusrca=10, alusrcb=01, aluop=10. Goes to ALUWB.
- **ALUWB**: resultsrc=00, regwrite=1. Goes to FETCH.
- **BEQ**: alusrca=10, alusrcb=00, aluop=01, resultsrc=00.
  - pcwrite = `zero`.
  - Goes to FETCH.
- **JAL**: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1. Goes to ALUWB.

Retirement counter:
- `instret` increments by 1 in each cycle that is one of: MEMWB, ALUWB, BEQ, MEMWRITE with `mem_ready`, or DECODE with `illegal`.
- It wraps modulo 2^`INSTRET_W`.

## Timing
- **Reset:** when `reset` is sampled high, state becomes FETCH and `instret` becomes 0.
  - While `reset` is high, pcwrite, irwrite, regwrite, memwrite and `illegal` are forced to 0. Selects show FETCH values.
  - Reset wins over any state, including mid-wait in MEMREAD or MEMWRITE. No write strobe appears in the reset cycle.
- **Outputs:** all outputs except `instret` are combinational from state, `op`, `zero` and `mem_ready`. `instret` is registered.
- **Latency** with `mem_ready` tied high:
  - beq: 3 cycles
  - R-type and I-ALU: 4 cycles
  - jal: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - illegal: 2 cycles
- **Memory wait:** each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting.
- **memwrite:** it remains asserted with a stable address until the cycle in which `mem_ready`=1. That cycle is the single cycle in which the write completes.

## Structure
Shared package `riscv_ctrl_pkg` holds:
- the state enum (4-bit encoding, FETCH = 0);
- the opcode constants;
- the `aluop`, `immsrc`, `resultsrc`, `alusrca` and `alusrcb` encodings.

One combinational sub-module, `imm_src_decoder`, maps `op` to `immsrc`. Everything else lives in one FSM module: a state register, next-state logic, output logic and the `instret` counter.

## Test plan
- **R-type:** reset, then add op 0110011 with `mem_ready`=1.
  - States FETCH → DECODE → EXECUTER → ALUWB → FETCH.
  - aluop=10 in EXECUTER; regwrite=1 only in ALUWB; `instret` goes 0 → 1.
- **lw with slow memory:** `mem_ready` low for 2 cycles in both FETCH and MEMREAD.
  - FETCH and MEMREAD each last 3 cycles.
  - irwrite pulses once; resultsrc=01 with regwrite=1 in MEMWB; total 9 cycles.
- **beq taken and not taken:**
  - `zero`=1 gives pcwrite=1 in BEQ with aluop=01.
  - `zero`=0 gives pcwrite=0.
  - `instret` increments in both cases.
- **sw with `mem_ready`=0 for 3 cycles in MEMWRITE:**
  - memwrite=1 and adrsrc=1 for 4 cycles, then FETCH.
  - regwrite is never asserted.
- **Illegal opcode 0000000:**
  - `illegal` is a single pulse in DECODE, then FETCH.
  - No enable asserted after fetch; `instret` increments.
- **Reset mid-MEMWRITE with `mem_ready`=0:**
  - Next cycle is FETCH and `instret`=0.
  - memwrite=0 in the reset cycle.
  - jal after reset gives pcwrite=1 in JAL, then regwrite=1 in ALUWB.
